// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and address decode for dmem_responder
// Purpose: the RAM/MMIO boundary, the MMIO register addresses, the STATUS bit
//          positions and the address decode helper. There are no ports.
package dmem_pkg;

    localparam logic [15:0] MMIO_BASE   = 16'hFF00;
    localparam logic [15:0] ADDR_LED    = 16'hFF00;
    localparam logic [15:0] ADDR_SW     = 16'hFF02;
    localparam logic [15:0] ADDR_CYCLE  = 16'hFF04;
    localparam logic [15:0] ADDR_STATUS = 16'hFF06;
    localparam logic [15:0] ADDR_WCOUNT = 16'hFF08;

    localparam int STAT_W        = 2;
    localparam int STAT_CONFLICT = 0;
    localparam int STAT_MISALIGN = 1;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_CYCLE,
        SEL_STATUS,
        SEL_WCOUNT,
        SEL_NONE
    } sel_e;

    // Bit 0 is dropped before decoding, so odd addresses select the same
    // target as the even address below them.
    function automatic sel_e decode(input logic [15:0] addr);
        logic [15:0] a;
        a = {addr[15:1], 1'b0};
        if (a < MMIO_BASE) return SEL_RAM;
        case (a)
            ADDR_LED:    return SEL_LED;
            ADDR_SW:     return SEL_SW;
            ADDR_CYCLE:  return SEL_CYCLE;
            ADDR_STATUS: return SEL_STATUS;
            ADDR_WCOUNT: return SEL_WCOUNT;
            default:     return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - 2^ADDR_BITS x 16 RAM, combinational read, synchronous write
// Ports: clk_i clock; we_i write enable; addr_i word index;
//        wdata_i write data; rdata_o read data (zero latency, pre-write value).
module dmem_ram #(
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [15:0]          wdata_i,
    output logic [15:0]          rdata_o
);

    logic [15:0] mem_q [0:(2**ADDR_BITS)-1];

    // Contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - CPU data-memory responder: RAM plus optional MMIO block
// Optional feature macro: DMEM_MMIO_EN (LED/SW/CYCLE/STATUS/WCOUNT registers).
// Ports: clock, reset (sync, active-high); dmemaddr byte address; dmemwdata;
//        dmemwrite; dmemread; dmemrdata combinational read data (0 when idle);
//        switches asynchronous input; leds LED register value.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] dmemaddr,
    input  logic [15:0] dmemwdata,
    input  logic        dmemwrite,
    input  logic        dmemread,
    output logic [15:0] dmemrdata,
    input  logic [7:0]  switches,
    output logic [7:0]  leds
);

    logic              is_ram;
    logic              ram_we;
    logic [15:0]       ram_rdata;
    logic [STAT_W-1:0] status_q, status_d, status_set, status_clr;

`ifdef DMEM_MMIO_EN
    sel_e        sel;
    logic [7:0]  led_q, led_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [15:0] cycle_q, cycle_d;
    logic [15:0] wcount_q, wcount_d;

    assign sel    = decode(dmemaddr);
    assign is_ram = (sel == SEL_RAM);
`else
    logic unused_nommio;
    assign unused_nommio = ^{switches, dmemaddr};
    assign is_ram        = 1'b1;
`endif

    // Writes are suppressed for the whole reset cycle, RAM included.
    assign ram_we = dmemwrite & is_ram & ~reset;

    dmem_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .addr_i  (dmemaddr[ADDR_BITS:1]),
        .wdata_i (dmemwdata),
        .rdata_o (ram_rdata)
    );

    // Sticky flags: a new event in the same cycle as a W1C clear wins.
    always_comb begin
        status_set                = '0;
        status_clr                = '0;
        status_set[STAT_CONFLICT] = dmemread & dmemwrite;
        status_set[STAT_MISALIGN] = (dmemread | dmemwrite) & dmemaddr[0];
`ifdef DMEM_MMIO_EN
        if (dmemwrite && sel == SEL_STATUS) status_clr = dmemwdata[STAT_W-1:0];
`endif
        status_d = (status_q & ~status_clr) | status_set;
    end

    always_ff @(posedge clock) begin
        if (reset) status_q <= '0;
        else       status_q <= status_d;
    end

`ifdef DMEM_MMIO_EN
    always_comb begin
        led_d = led_q;
        if (dmemwrite && sel == SEL_LED) led_d = dmemwdata[7:0];
        cycle_d  = cycle_q + 16'd1;
        wcount_d = wcount_q;
        if (ram_we && wcount_q != 16'hFFFF) wcount_d = wcount_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cycle_q   <= '0;
            wcount_q  <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            cycle_q   <= cycle_d;
            wcount_q  <= wcount_d;
        end
    end

    assign leds = led_q;

    always_comb begin
        dmemrdata = 16'h0000;
        if (dmemread) begin
            case (sel)
                SEL_RAM:    dmemrdata = ram_rdata;
                SEL_LED:    dmemrdata = {8'h00, led_q};
                SEL_SW:     dmemrdata = {8'h00, sw_sync_q};
                SEL_CYCLE:  dmemrdata = cycle_q;
                SEL_STATUS: dmemrdata = {{(16-STAT_W){1'b0}}, status_q};
                SEL_WCOUNT: dmemrdata = wcount_q;
                default:    dmemrdata = 16'h0000;
            endcase
        end
    end
`else
    assign leds = 8'h00;

    always_comb begin
        dmemrdata = 16'h0000;
        if (dmemread) dmemrdata = ram_rdata;
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder (both builds via DMEM_MMIO_EN)
module tb_dmem_responder;

    logic        clock;
    logic        reset;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;
    logic [7:0]  switches;
    logic [7:0]  leds;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_responder #(.ADDR_BITS(7)) dut (
        .clock     (clock),
        .reset     (reset),
        .dmemaddr  (dmemaddr),
        .dmemwdata (dmemwdata),
        .dmemwrite (dmemwrite),
        .dmemread  (dmemread),
        .dmemrdata (dmemrdata),
        .switches  (switches),
        .leds      (leds)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        re;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(input logic re, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata);
        dmemread  = re;
        dmemwrite = we;
        dmemaddr  = addr;
        dmemwdata = wdata;
    endtask

    // Applies one access in the low clock phase and checks read data before
    // the rising edge that commits it.
    task automatic access(input logic re, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp,
                          input string name);
        @(negedge clock);
        drive(re, we, addr, wdata);
        #1;
        chk(name, dmemrdata, exp);
    endtask

    task automatic idle();
        @(negedge clock);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        reset    = 1'b1;
        switches = 8'h00;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_leds", {8'h00, leds}, 16'h0000);
        chk("reset_rdata_idle", dmemrdata, 16'h0000);
        reset = 1'b0;

        //              re    we    addr      wdata     expected rdata
        vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        vecs[2]  = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h1234};
        vecs[3]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[4]  = '{1'b0, 1'b1, 16'h0100, 16'hAAAA, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hAAAA};
        vecs[6]  = '{1'b0, 1'b1, 16'h0002, 16'h5555, 16'h0000};
        vecs[7]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h5555};
        vecs[8]  = '{1'b0, 1'b1, 16'h00FE, 16'h0F0F, 16'h0000};
        vecs[9]  = '{1'b1, 1'b0, 16'h01FE, 16'h0000, 16'h0F0F};
        vecs[10] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000};
        vecs[11] = '{1'b1, 1'b0, 16'h0110, 16'h0000, 16'hBEEF};

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                   $sformatf("vec%0d", i));
        end

`ifdef DMEM_MMIO_EN
        // Conflict (vec2) and misalign (vec7) flags are both sticky.
        access(1'b1, 1'b0, 16'hFF06, 16'h0000, 16'h0003, "status_both");
        access(1'b1, 1'b0, 16'hFF08, 16'h0000, 16'h0005, "wcount_5");
        // Misaligned W1C write: clears both, misalign re-set the same cycle.
        access(1'b0, 1'b1, 16'hFF07, 16'h0003, 16'h0000, "w1c_misaligned");
        access(1'b1, 1'b0, 16'hFF06, 16'h0000, 16'h0002, "status_set_wins");
        access(1'b0, 1'b1, 16'hFF06, 16'h0002, 16'h0000, "w1c_aligned");
        access(1'b1, 1'b0, 16'hFF06, 16'h0000, 16'h0000, "status_cleared");
        access(1'b0, 1'b1, 16'hFF00, 16'h01C3, 16'h0000, "led_write");
        access(1'b1, 1'b0, 16'hFF00, 16'h0000, 16'h00C3, "led_read");
        chk("leds_out", {8'h00, leds}, 16'h00C3);
        access(1'b0, 1'b1, 16'hFF08, 16'hFFFF, 16'h0000, "wcount_ro_write");
        access(1'b1, 1'b0, 16'hFF08, 16'h0000, 16'h0005, "wcount_ro_kept");
        access(1'b1, 1'b0, 16'hFF0A, 16'h0000, 16'h0000, "unmapped_ff0a");
        access(1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, "unmapped_fffe");

        @(negedge clock);
        switches = 8'h5A;
        access(1'b1, 1'b0, 16'hFF02, 16'h0000, 16'h0000, "sw_t1_old");
        access(1'b1, 1'b0, 16'hFF02, 16'h0000, 16'h005A, "sw_t2_new");
`else
        access(1'b0, 1'b1, 16'hFF00, 16'h4321, 16'h0000, "nommio_ff00_write");
        access(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h4321, "nommio_alias_word0");
        access(1'b0, 1'b1, 16'h0006, 16'h6666, 16'h0000, "nommio_word3_write");
        access(1'b1, 1'b0, 16'hFF06, 16'h0000, 16'h6666, "nommio_ff06_ram");
        chk("nommio_leds", {8'h00, leds}, 16'h0000);
`endif

        // Reset landing on a RAM write must drop the write.
        access(1'b0, 1'b1, 16'h0020, 16'h7777, 16'h0000, "pre_rst_write");
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b1, 16'h0020, 16'h9999);
        access(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h7777, "rd_during_reset");
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        #1;
        chk("rst_write_blocked", dmemrdata, 16'h7777);
`ifdef DMEM_MMIO_EN
        drive(1'b1, 1'b0, 16'hFF00, 16'h0000);
        #1 chk("rst_led", dmemrdata, 16'h0000);
        chk("rst_leds_out", {8'h00, leds}, 16'h0000);
        drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
        #1 chk("rst_wcount", dmemrdata, 16'h0000);
        drive(1'b1, 1'b0, 16'hFF06, 16'h0000);
        #1 chk("rst_status", dmemrdata, 16'h0000);
        drive(1'b1, 1'b0, 16'hFF04, 16'h0000);
        #1 chk("cycle_at_release", dmemrdata, 16'h0000);
        repeat (5) @(posedge clock);
        @(negedge clock);
        #1 chk("cycle_5", dmemrdata, 16'h0005);
        // 65531 more edges totals 65536 since release: wrapped to zero.
        repeat (65531) @(posedge clock);
        @(negedge clock);
        #1 chk("cycle_wrap", dmemrdata, 16'h0000);
`endif
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
